// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - LSU shared types: funct3 codes, FSM states, decode helpers
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_LB, F3_LH, F3_LW: ok = 1'b1;
      F3_LBU, F3_LHU:      ok = !wr;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == SZ_H) && off[0]) || ((f3[1:0] == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// rtl/load_store_unit_align.sv - byte enables, store lane replication, load extract/extend
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        be_o    = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ld_funct3_i)
      F3_LB:   ld_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   ld_data_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  ld_data_o = {24'h0, byte_sel};
      F3_LHU:  ld_data_o = {16'h0, half_sel};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory access stage with req/ack bus and core stall
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses fault without touching the bus.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             we_q;
  logic             ld_valid_q, fault_q;
  logic [31:0]      ld_data_q;
  logic             bus_req_q, bus_we_q;
  logic [31:0]      bus_addr_q, bus_wdata_q;
  logic [3:0]       bus_be_q;

  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] ld_data_d;
  logic        reject_d;

  load_store_unit_align u_align (
    .size_i      (req_funct3[1:0]),
    .off_i       (req_addr[1:0]),
    .wdata_i     (req_wdata),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .rdata_i     (bus_rdata),
    .be_o        (be_d),
    .wdata_o     (wdata_d),
    .ld_data_o   (ld_data_d)
  );

  always_comb begin
    reject_d = !f3_legal(req_write, req_funct3);
`ifdef MISALIGN_TRAP_EN
    reject_d = reject_d | misaligned(req_funct3, req_addr[1:0]);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      we_q        <= 1'b0;
      ld_valid_q  <= 1'b0;
      fault_q     <= 1'b0;
      ld_data_q   <= 32'h0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ld_valid_q <= 1'b0;
          fault_q    <= 1'b0;
          ld_data_q  <= 32'h0;
          if (req_valid) begin
            f3_q  <= req_funct3;
            off_q <= req_addr[1:0];
            we_q  <= req_write;
            cnt_q <= '0;
            if (reject_d) begin
              // Rejected instructions complete immediately; loads still write back a zero.
              state_q    <= ST_DONE;
              fault_q    <= 1'b1;
              ld_valid_q <= !req_write;
            end else begin
              state_q     <= ST_REQ;
              bus_req_q   <= 1'b1;
              bus_we_q    <= req_write;
              bus_addr_q  <= {req_addr[31:2], 2'b00};
              bus_be_q    <= be_d;
              bus_wdata_q <= req_write ? wdata_d : 32'h0;
            end
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            state_q    <= ST_DONE;
            bus_req_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_be_q   <= 4'b0000;
            ld_valid_q <= !we_q;
            ld_data_q  <= we_q ? 32'h0 : ld_data_d;
          end else if (cnt_q == TO_LAST) begin
            state_q    <= ST_DONE;
            bus_req_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_be_q   <= 4'b0000;
            fault_q    <= 1'b1;
            ld_valid_q <= !we_q;
            ld_data_q  <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          cnt_q      <= '0;
          ld_valid_q <= 1'b0;
          fault_q    <= 1'b0;
          ld_data_q  <= 32'h0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Gating with rst lets the core run free the instant reset is applied mid-access.
  assign stall     = req_valid & (state_q != ST_DONE) & ~rst;
  assign ld_valid  = ld_valid_q;
  assign ld_data   = ld_data_q;
  assign fault     = fault_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, ld_valid, fault;
  logic [31:0] ld_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
  } bus_exp_t;

  typedef struct {
    logic        ldv;
    logic        flt;
    logic [31:0] data;
  } cmp_exp_t;

  bus_exp_t bq[$];
  cmp_exp_t cq[$];

  load_store_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    errors++;
    $display("FAIL %s: unexpected event", name);
  endtask

  task automatic exp_bus(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
    bus_exp_t e;
    e.addr = a; e.be = be; e.we = we; e.wd = wd;
    bq.push_back(e);
  endtask

  task automatic exp_cmp(input logic v, input logic f, input logic [31:0] d);
    cmp_exp_t e;
    e.ldv = v; e.flt = f; e.data = d;
    cq.push_back(e);
  endtask

  // Drives one instruction, answers the bus after ack_at REQ cycles (-1: never).
  task automatic access(input string name, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int ack_at,
                        input logic [31:0] rd, input int exp_stall, input int exp_req);
    int n, rc, t;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0; rc = 0; t = 0;
    while (t < 200) begin
      if (bus_req) begin
        bus_ack   = (rc == ack_at);
        bus_rdata = (rc == ack_at) ? rd : 32'h0;
        rc++;
      end else begin
        bus_ack = 1'b0;
      end
      #1;
      if (!stall) break;
      n++;
      @(negedge clk);
      t++;
    end
    bus_ack = 1'b0;
    if (t >= 200) flag({name, "_hang"});
    chk({name, "_stall_cycles"}, n, exp_stall);
    chk({name, "_req_cycles"}, rc, exp_req);
  endtask

  initial begin : monitor
    bus_exp_t b;
    cmp_exp_t c;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus_req && !prev) begin
          if (bq.size() == 0) flag("bus_req_unexpected");
          else begin
            b = bq.pop_front();
            chk("bus_addr", bus_addr, b.addr);
            chk("bus_be", {28'h0, bus_be}, {28'h0, b.be});
            chk("bus_we", {31'h0, bus_we}, {31'h0, b.we});
            chk("bus_wdata", bus_wdata, b.wd);
          end
        end
        if (ld_valid || fault) begin
          if (cq.size() == 0) flag("completion_unexpected");
          else begin
            c = cq.pop_front();
            chk("ld_valid", {31'h0, ld_valid}, {31'h0, c.ldv});
            chk("fault", {31'h0, fault}, {31'h0, c.flt});
            chk("ld_data", ld_data, c.data);
          end
        end
      end
      prev = bus_req;
    end
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_ld_valid", {31'h0, ld_valid}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_bus_be", {28'h0, bus_be}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    rst = 1'b0;

    exp_bus(32'h104, 4'b1111, 1'b0, 32'h0); exp_cmp(1'b1, 1'b0, 32'hDEADBEEF);
    access("lw", 1'b0, 3'b010, 32'h104, 32'h0, 0, 32'hDEADBEEF, 2, 1);
    exp_bus(32'h200, 4'b1000, 1'b0, 32'h0); exp_cmp(1'b1, 1'b0, 32'hFFFFFF80);
    access("lb", 1'b0, 3'b000, 32'h203, 32'h0, 0, 32'h80112233, 2, 1);
    exp_bus(32'h200, 4'b1000, 1'b0, 32'h0); exp_cmp(1'b1, 1'b0, 32'h00000080);
    access("lbu", 1'b0, 3'b100, 32'h203, 32'h0, 0, 32'h80112233, 2, 1);
    exp_bus(32'h200, 4'b1100, 1'b0, 32'h0); exp_cmp(1'b1, 1'b0, 32'hFFFF8011);
    access("lh", 1'b0, 3'b001, 32'h202, 32'h0, 0, 32'h80112233, 2, 1);
    exp_bus(32'h200, 4'b1100, 1'b0, 32'h0); exp_cmp(1'b1, 1'b0, 32'h00008011);
    access("lhu", 1'b0, 3'b101, 32'h202, 32'h0, 0, 32'h80112233, 2, 1);
    exp_bus(32'h200, 4'b0010, 1'b0, 32'h0); exp_cmp(1'b1, 1'b0, 32'h00000022);
    access("lb_lane1", 1'b0, 3'b000, 32'h201, 32'h0, 0, 32'h80112233, 2, 1);
    exp_bus(32'h200, 4'b0011, 1'b0, 32'h0); exp_cmp(1'b1, 1'b0, 32'h00002233);
    access("lh_lane0", 1'b0, 3'b001, 32'h200, 32'h0, 0, 32'h80112233, 2, 1);

    exp_bus(32'h10, 4'b0010, 1'b1, 32'hA5A5A5A5);
    access("sb", 1'b1, 3'b000, 32'h11, 32'h000000A5, 0, 32'h0, 2, 1);
    exp_bus(32'h14, 4'b1100, 1'b1, 32'hBEEFBEEF);
    access("sh", 1'b1, 3'b001, 32'h16, 32'h1234BEEF, 0, 32'h0, 2, 1);
    exp_bus(32'h20, 4'b1111, 1'b1, 32'hCAFEF00D);
    access("sw", 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 0, 32'h0, 2, 1);

    exp_bus(32'h300, 4'b1111, 1'b0, 32'h0); exp_cmp(1'b1, 1'b0, 32'h0BADF00D);
    access("lw_slow", 1'b0, 3'b010, 32'h300, 32'h0, 3, 32'h0BADF00D, 5, 4);
    exp_bus(32'h400, 4'b1111, 1'b0, 32'h0); exp_cmp(1'b1, 1'b1, 32'h0);
    access("lw_timeout", 1'b0, 3'b010, 32'h400, 32'h0, -1, 32'h0, 17, 16);
    exp_bus(32'h404, 4'b1111, 1'b1, 32'h55AA55AA); exp_cmp(1'b0, 1'b1, 32'h0);
    access("sw_timeout", 1'b1, 3'b010, 32'h404, 32'h55AA55AA, -1, 32'h0, 17, 16);

    exp_cmp(1'b1, 1'b1, 32'h0);
    access("ld_bad_f3", 1'b0, 3'b011, 32'h500, 32'h0, 0, 32'h0, 1, 0);
    exp_cmp(1'b0, 1'b1, 32'h0);
    access("st_bad_f3", 1'b1, 3'b100, 32'h500, 32'h12345678, 0, 32'h0, 1, 0);

`ifdef MISALIGN_TRAP_EN
    exp_cmp(1'b1, 1'b1, 32'h0);
    access("lw_misaligned", 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h11223344, 1, 0);
    exp_cmp(1'b1, 1'b1, 32'h0);
    access("lh_misaligned", 1'b0, 3'b001, 32'h203, 32'h0, 0, 32'h80112233, 1, 0);
`else
    exp_bus(32'h100, 4'b1111, 1'b0, 32'h0); exp_cmp(1'b1, 1'b0, 32'h11223344);
    access("lw_misaligned", 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h11223344, 2, 1);
    exp_bus(32'h200, 4'b1100, 1'b0, 32'h0); exp_cmp(1'b1, 1'b0, 32'hFFFF8011);
    access("lh_misaligned", 1'b0, 3'b001, 32'h203, 32'h0, 0, 32'h80112233, 2, 1);
`endif

    // Reset while the bus request is outstanding.
    exp_bus(32'h600, 4'b1111, 1'b0, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h600;
    @(negedge clk);
    #2;
    chk("mid_bus_req_before_rst", {31'h0, bus_req}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_bus_req", {31'h0, bus_req}, 32'h0);
    chk("mid_rst_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("late_ack_bus_req", {31'h0, bus_req}, 32'h0);
    @(negedge clk);
    chk("late_ack_ld_valid", {31'h0, ld_valid}, 32'h0);
    chk("late_ack_fault", {31'h0, fault}, 32'h0);

    exp_bus(32'h700, 4'b1111, 1'b0, 32'h0); exp_cmp(1'b1, 1'b0, 32'h13579BDF);
    access("lw_after_rst", 1'b0, 3'b010, 32'h700, 32'h0, 0, 32'h13579BDF, 2, 1);

    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("bus_queue_drained", bq.size(), 32'h0);
    chk("cmp_queue_drained", cq.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
